// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with a persistent NZCV flag register and an iterative shift-add multiplier.
// Ops 0-6 complete one edge after accept; MUL takes WIDTH edges with in_ready low, and start is ignored while busy.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             in_ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;
  state_t state, state_nxt;

  logic [2*WIDTH-1:0] mcand, acc, acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             wr, load_mul;
  logic [WIDTH-1:0] res_nxt;
  logic             c_nxt, v_nxt;

  // op[1] selects subtract (~B); op[0] selects the stored carry as carry-in.
  assign y        = op[1] ? ~b : b;
  assign cin      = op[0] ? c : op[1];
  assign sum      = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  assign acc_step = mplier[0] ? acc + mcand : acc;

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    wr        = 1'b0;
    load_mul  = 1'b0;
    res_nxt   = '0;
    c_nxt     = 1'b0;
    v_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd4: begin wr = 1'b1; res_nxt = a & b; end
            3'd5: begin wr = 1'b1; res_nxt = a | b; end
            3'd6: begin wr = 1'b1; res_nxt = a ^ b; end
            3'd7: begin load_mul = 1'b1; state_nxt = MUL; end
            default: begin
              wr      = 1'b1;
              res_nxt = sum[WIDTH-1:0];
              c_nxt   = sum[WIDTH];
              // carry into MSB recovered from the MSB sum bit and its operands
              v_nxt   = sum[WIDTH] ^ (sum[WIDTH-1] ^ a[WIDTH-1] ^ y[WIDTH-1]);
            end
          endcase
        end
      end
      MUL: begin
        if (cnt == LAST) begin
          wr        = 1'b1;
          res_nxt   = acc_step[WIDTH-1:0];
          c_nxt     = |acc_step[2*WIDTH-1:WIDTH];
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= '0;
      n      <= 1'b0;
      z      <= 1'b0;
      c      <= 1'b0;
      v      <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      done  <= wr;
      if (wr) begin
        result <= res_nxt;
        n      <= res_nxt[WIDTH-1];
        z      <= (res_nxt == '0);
        c      <= c_nxt;
        v      <= v_nxt;
      end
      if (load_mul) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == MUL) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq (WIDTH=16) against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          in_ready, done;
  logic [W-1:0]  result;
  logic          n, z, c, v;

  // reference state
  logic [W-1:0]  mr;
  logic          mn, mz, mc, mv;

  int n_chk  = 0;
  int n_pass = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .in_ready(in_ready), .done(done), .result(result),
    .n(n), .z(z), .c(c), .v(v)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: flags from plain integer arithmetic and sign rules.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] yv);
    int unsigned     s;
    int unsigned     ci;
    logic [W-1:0]    yy;
    longint unsigned p;
    case (o)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        yy = (o >= 3'd2) ? ~yv : yv;
        if (o == 3'd0)      ci = 0;
        else if (o == 3'd2) ci = 1;
        else                ci = mc ? 1 : 0;
        s  = x + yy + ci;
        mr = s[W-1:0];
        mc = s[W];
        mv = (x[W-1] == yy[W-1]) && (mr[W-1] != x[W-1]);
      end
      3'd4: begin mr = x & yv; mc = 0; mv = 0; end
      3'd5: begin mr = x | yv; mc = 0; mv = 0; end
      3'd6: begin mr = x ^ yv; mc = 0; mv = 0; end
      default: begin
        p  = longint'(x) * longint'(yv);
        mr = p[W-1:0];
        mc = (p[2*W-1:W] != 0);
        mv = 0;
      end
    endcase
    mn = mr[W-1];
    mz = (mr == 0);
  endtask

  task automatic check_outputs(input string tag, input logic exp_done);
    chk({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, ".rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ".res"}, {16'd0, result}, {16'd0, mr});
    chk({tag, ".nzcv"}, {28'd0, n, z, c, v}, {28'd0, mn, mz, mc, mv});
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] yv);
    start = 1'b1; op = o; a = x; b = yv;
    @(posedge clk); #1;
    start = 1'b0;
    model(o, x, yv);
    check_outputs($sformatf("op%0d", o), 1'b1);
  endtask

  task automatic idle_cycle();
    start = 1'b0;
    @(posedge clk); #1;
    check_outputs("idle", 1'b0);
  endtask

  task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] yv, input bit junk);
    start = 1'b1; op = 3'd7; a = x; b = yv;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("mul.busy", {31'd0, in_ready}, 32'd0);
      chk("mul.nodone", {31'd0, done}, 32'd0);
      if (junk) begin
        start = 1'b1;
        op = 3'($urandom_range(0, 7));
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    model(3'd7, x, yv);
    check_outputs("mul", 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    mr = '0; mn = 0; mz = 0; mc = 0; mv = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdy", {31'd0, in_ready}, 32'd1);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.res", {16'd0, result}, 32'd0);
    chk("rst.nzcv", {28'd0, n, z, c, v}, 32'd0);
    rst = 1'b0;

    do_op(3'd0, 16'h7FFF, 16'h0001);
    chk("add.lit", {16'd0, result, n, z, c, v}, {16'd0, 16'h8000, 4'b1001});
    idle_cycle();
    do_op(3'd2, 16'h0005, 16'h0005);
    chk("sub0.lit", {16'd0, result, n, z, c, v}, {16'd0, 16'h0000, 4'b0110});
    do_op(3'd2, 16'h0003, 16'h0005);
    chk("subneg.lit", {16'd0, result, n, z, c, v}, {16'd0, 16'hFFFE, 4'b1000});

    // multi-word chains, back-to-back
    do_op(3'd0, 16'hFFFF, 16'h0001);
    chk("wrap.lit", {16'd0, result, n, z, c, v}, {16'd0, 16'h0000, 4'b0110});
    do_op(3'd1, 16'h0001, 16'h0000);
    chk("adc.lit", {16'd0, result, c}, {15'd0, 16'h0002, 1'b0});
    do_op(3'd2, 16'h0000, 16'h0001);
    chk("sbc0.lit", {16'd0, result, c}, {15'd0, 16'hFFFF, 1'b0});
    do_op(3'd3, 16'h0002, 16'h0000);
    chk("sbc1.lit", {16'd0, result}, {16'd0, 16'h0001});

    // logic ops clear c/v even after c=1
    do_op(3'd0, 16'hFFFF, 16'h0001);
    do_op(3'd4, 16'hF0F0, 16'h0FF0);
    chk("and.lit", {16'd0, result, c, v}, {14'd0, 16'h00F0, 2'b00});
    do_op(3'd6, 16'hAAAA, 16'hAAAA);
    chk("xor.lit", {16'd0, result, z}, {15'd0, 16'h0000, 1'b1});
    idle_cycle();

    do_mul(16'h0123, 16'h0010, 1'b1);
    chk("mul.lit", {16'd0, result, c}, {15'd0, 16'h1230, 1'b0});
    idle_cycle();
    do_mul(16'h0100, 16'h0100, 1'b0);
    chk("mulovf.lit", {16'd0, result, z, c}, {14'd0, 16'h0000, 2'b11});
    do_op(3'd5, 16'h1200, 16'h0034);

    // reset during MUL after 7 steps
    start = 1'b1; op = 3'd7; a = 16'h00FF; b = 16'h00FF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mr = '0; mn = 0; mz = 0; mc = 0; mv = 0;
    check_outputs("midrst", 1'b0);
    do_op(3'd0, 16'h0002, 16'h0003);
    chk("postrst.lit", {16'd0, result}, 32'h5);

    for (int i = 0; i < 150; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 4) == 0) ra = '1;
      if ($urandom_range(0, 4) == 0) rb = W'($urandom_range(0, 2));
      if (ro == 3'd7) do_mul(ra, rb, bit'($urandom_range(0, 1)));
      else            do_op(ro, ra, rb);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
